// File: rtl/controller_poll_multi.sv
// Polls NUM_CH serial game pads in parallel over a shared latch/clock and publishes inverted,
// registered button words. Define CONT_DEBOUNCE_EN to accept a word only after two equal polls.
module controller_poll_multi #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned NUM_BITS    = 8,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned POLL_PERIOD = 0
) (
  input  logic                         PCLK,
  input  logic                         MSS_RESET_N,
  input  logic                         start,
  input  logic                         auto_en,
  input  logic [NUM_CH-1:0]            contRead,
  output logic                         contWrite,
  output logic                         contCLK,
  output logic [NUM_CH*NUM_BITS-1:0]   buttons,
  output logic [NUM_CH-1:0]            changed,
  output logic                         valid,
  output logic                         busy
);

  localparam int unsigned BitW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned TmrW = (POLL_PERIOD > 0) ? $clog2(POLL_PERIOD + 1) : 1;
  localparam int unsigned W    = NUM_CH * NUM_BITS;

  localparam logic [BitW-1:0] BitMax = BitW'(NUM_BITS - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

  typedef enum logic [2:0] {StIdle, StLatch, StSample, StClkHi, StDone} state_e;

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [W-1:0]      btn_q, btn_d;
  logic [NUM_CH-1:0] chg_q, chg_d;
  logic              valid_q, valid_d;
  logic              cont_write_q, cont_clk_q, busy_q;
`ifdef CONT_DEBOUNCE_EN
  logic [W-1:0]      raw_q, raw_d;
`endif

  logic tick;
  logic auto_req;

  assign tick     = (state_q != StIdle) && (div_q == DivMax);
  assign auto_req = auto_en && (POLL_PERIOD != 0) && (tmr_q == TmrMax);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = div_q;
    tmr_d   = tmr_q;
    shift_d = shift_q;
    btn_d   = btn_q;
    chg_d   = '0;
    valid_d = 1'b0;
`ifdef CONT_DEBOUNCE_EN
    raw_d   = raw_q;
`endif

    // Timer saturates at expiry so a request raised while busy waits for IDLE.
    if (auto_en && (tmr_q != TmrMax)) tmr_d = tmr_q + 1'b1;
    if (state_q != StIdle) div_d = tick ? '0 : div_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start || auto_req) begin
          state_d = StLatch;
          div_d   = '0;
          bit_d   = '0;
          tmr_d   = '0;
        end
      end
      StLatch: begin
        // bit_q doubles as the latch tick count.
        if (tick) begin
          if (bit_q == BitW'(1)) begin
            state_d = StSample;
            bit_d   = '0;
          end else begin
            bit_d = BitW'(1);
          end
        end
      end
      StSample: begin
        if (tick) begin
          for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NUM_BITS; b++) begin
              if (bit_q == BitW'(b)) shift_d[c*NUM_BITS+b] = ~contRead[c];
            end
          end
          state_d = (bit_q == BitMax) ? StDone : StClkHi;
        end
      end
      StClkHi: begin
        if (tick) begin
          bit_d   = bit_q + 1'b1;
          state_d = StSample;
        end
      end
      StDone: begin
        state_d = StIdle;
        valid_d = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef CONT_DEBOUNCE_EN
          if (shift_q[c*NUM_BITS +: NUM_BITS] == raw_q[c*NUM_BITS +: NUM_BITS]) begin
            btn_d[c*NUM_BITS +: NUM_BITS] = shift_q[c*NUM_BITS +: NUM_BITS];
            chg_d[c] = shift_q[c*NUM_BITS +: NUM_BITS] != btn_q[c*NUM_BITS +: NUM_BITS];
          end
          raw_d[c*NUM_BITS +: NUM_BITS] = shift_q[c*NUM_BITS +: NUM_BITS];
`else
          btn_d[c*NUM_BITS +: NUM_BITS] = shift_q[c*NUM_BITS +: NUM_BITS];
          chg_d[c] = shift_q[c*NUM_BITS +: NUM_BITS] != btn_q[c*NUM_BITS +: NUM_BITS];
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pad-facing strobes are registered from the next state so they are glitch-free.
  always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q      <= StIdle;
      bit_q        <= '0;
      div_q        <= '0;
      tmr_q        <= '0;
      shift_q      <= '0;
      btn_q        <= '0;
      chg_q        <= '0;
      valid_q      <= 1'b0;
      cont_write_q <= 1'b0;
      cont_clk_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CONT_DEBOUNCE_EN
      raw_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      tmr_q        <= tmr_d;
      shift_q      <= shift_d;
      btn_q        <= btn_d;
      chg_q        <= chg_d;
      valid_q      <= valid_d;
      cont_write_q <= (state_d == StLatch);
      cont_clk_q   <= (state_d == StClkHi);
      busy_q       <= (state_d != StIdle);
`ifdef CONT_DEBOUNCE_EN
      raw_q        <= raw_d;
`endif
    end
  end

  assign contWrite = cont_write_q;
  assign contCLK   = cont_clk_q;
  assign buttons   = btn_q;
  assign changed   = chg_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_controller_poll_multi.sv
// Randomised bench for controller_poll_multi: behavioural pad model plus a word-level
// reference of what each poll should publish (handles CONT_DEBOUNCE_EN too).
module tb_controller_poll_multi;

  localparam int NC  = 2;
  localparam int NB  = 8;
  localparam int CD  = 4;
  localparam int PP  = 100;
  localparam int LAT = (2 * NB + 1) * CD + 1;

  logic              PCLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              auto_en = 1'b0;
  logic [NC-1:0]     contRead;
  logic              contWrite, contCLK, valid, busy;
  logic [NC*NB-1:0]  buttons;
  logic [NC-1:0]     changed;

  int n_tests = 0;
  int n_fail  = 0;

  controller_poll_multi #(
    .NUM_CH(NC), .NUM_BITS(NB), .CLK_DIV(CD), .POLL_PERIOD(PP)
  ) dut (
    .PCLK(PCLK), .MSS_RESET_N(rst_n), .start(start), .auto_en(auto_en),
    .contRead(contRead), .contWrite(contWrite), .contCLK(contCLK),
    .buttons(buttons), .changed(changed), .valid(valid), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // Pad: latch loads the word, each contCLK rise presents the next button; wire is active-low.
  logic [NB-1:0] pad_word [NC];
  logic [NB-1:0] pad_sr   [NC];

  always @(posedge contCLK or posedge contWrite) begin
    for (int c = 0; c < NC; c++) begin
      if (contWrite) pad_sr[c] <= pad_word[c];
      else           pad_sr[c] <= pad_sr[c] >> 1;
    end
  end

  always_comb begin
    contRead = '0;
    for (int c = 0; c < NC; c++) contRead[c] = ~pad_sr[c][0];
  end

  // Reference: what the published word / changed flags should be after each poll.
  logic [NB-1:0] exp_btn  [NC];
  logic [NB-1:0] raw_prev [NC];
  logic [NC-1:0] exp_chg;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      exp_btn[c]  = '0;
      raw_prev[c] = '0;
    end
    exp_chg = '0;
  endtask

  task automatic model_poll();
    for (int c = 0; c < NC; c++) begin
`ifdef CONT_DEBOUNCE_EN
      if (pad_word[c] == raw_prev[c]) begin
        exp_chg[c] = (pad_word[c] != exp_btn[c]);
        exp_btn[c] = pad_word[c];
      end else begin
        exp_chg[c] = 1'b0;
      end
      raw_prev[c] = pad_word[c];
`else
      exp_chg[c] = (pad_word[c] != exp_btn[c]);
      exp_btn[c] = pad_word[c];
`endif
    end
  endtask

  function automatic logic [NC*NB-1:0] exp_flat();
    logic [NC*NB-1:0] r;
    for (int c = 0; c < NC; c++) r[c*NB +: NB] = exp_btn[c];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge PCLK);
    rst_n = 1'b0;
    repeat (2) @(negedge PCLK);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One start-triggered poll, checking latency, strobe shape and the published result.
  task automatic do_poll(input string name, input logic [NB-1:0] w0, input logic [NB-1:0] w1,
                         input int restart_at);
    int cw_cnt = 0, rises = 0, bad_width = 0, hi_len = 0;
    int valid_cnt = 0, valid_at = -1, busy_bad = 0;
    logic prev_clk = 1'b0;
    pad_word[0] = w0;
    pad_word[1] = w1;
    @(negedge PCLK);
    start = 1'b1;
    @(posedge PCLK);
    #1 start = 1'b0;
    model_poll();
    for (int n = 0; n <= LAT + 20; n++) begin
      if (n > 0) begin
        @(posedge PCLK);
        #1;
      end
      start = (n == restart_at);
      cw_cnt += int'(contWrite);
      if (contCLK && !prev_clk) begin
        rises++;
        hi_len = 1;
      end else if (contCLK) begin
        hi_len++;
      end
      if (!contCLK && prev_clk && hi_len != CD) bad_width++;
      prev_clk = contCLK;
      if (busy !== (n < LAT)) busy_bad++;
      if (valid) begin
        valid_cnt++;
        valid_at = n;
        n_tests++;
        if (buttons !== exp_flat()) begin
          n_fail++;
          $display("FAIL %s buttons: got %h want %h", name, buttons, exp_flat());
        end
        n_tests++;
        if (changed !== exp_chg) begin
          n_fail++;
          $display("FAIL %s changed: got %b want %b", name, changed, exp_chg);
        end
      end
    end
    start = 1'b0;
    n_tests++;
    if (valid_cnt != 1 || valid_at != LAT) begin
      n_fail++;
      $display("FAIL %s valid: count %0d at %0d, want 1 at %0d", name, valid_cnt, valid_at, LAT);
    end
    n_tests++;
    if (cw_cnt != 2 * CD) begin
      n_fail++;
      $display("FAIL %s latch_cycles: got %0d want %0d", name, cw_cnt, 2 * CD);
    end
    n_tests++;
    if (rises != NB - 1 || bad_width != 0) begin
      n_fail++;
      $display("FAIL %s clk_pulses: got %0d (bad widths %0d) want %0d of %0d cycles",
               name, rises, bad_width, NB - 1, CD);
    end
    n_tests++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy: %0d wrong cycles, want 0", name, busy_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge PCLK);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 40; n++) begin
      @(posedge PCLK);
      #1;
      n_tests++;
      if ({contWrite, contCLK, busy, valid, changed, buttons} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: got cw=%b ck=%b busy=%b v=%b chg=%b btn=%h want all 0",
                 contWrite, contCLK, busy, valid, changed, buttons);
      end
    end
  endtask

  task automatic test_basic();
    do_poll("basic", 8'hA5, 8'h3C, -1);
`ifndef CONT_DEBOUNCE_EN
    n_tests++;
    if (buttons !== 16'h3CA5) begin
      n_fail++;
      $display("FAIL basic_word: got %h want 3ca5", buttons);
    end
`endif
    do_poll("repeat", 8'hA5, 8'h3C, -1);
  endtask

  task automatic test_busy_start();
    do_poll("busy_start", 8'($urandom), 8'($urandom), 20);
  endtask

  task automatic test_random();
    logic [NB-1:0] w0, w1;
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 2) != 0) w0 = 8'($urandom);
      if ($urandom_range(0, 2) != 0) w1 = 8'($urandom);
      do_poll("random", w0, w1, -1);
    end
  endtask

  task automatic test_mid_reset();
    pad_word[0] = 8'($urandom);
    pad_word[1] = 8'($urandom);
    @(negedge PCLK);
    start = 1'b1;
    @(posedge PCLK);
    #1 start = 1'b0;
    repeat (40) @(posedge PCLK);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({contWrite, contCLK, busy, valid, changed, buttons} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got cw=%b ck=%b busy=%b v=%b chg=%b btn=%h want all 0",
               contWrite, contCLK, busy, valid, changed, buttons);
    end
    @(negedge PCLK);
    rst_n = 1'b1;
    model_reset();
    do_poll("after_reset", 8'($urandom), 8'($urandom), -1);
  endtask

  task automatic test_auto();
    int rises[$];
    logic prev_cw;
    int got_valid = 0, extra = 0;
    pad_word[0] = 8'($urandom);
    pad_word[1] = 8'($urandom);
    @(negedge PCLK);
    auto_en = 1'b1;
    prev_cw = contWrite;
    for (int n = 0; n < 600 && rises.size() < 3; n++) begin
      @(posedge PCLK);
      #1;
      if (contWrite && !prev_cw) rises.push_back(n);
      prev_cw = contWrite;
      if (valid) begin
        model_poll();
        n_tests++;
        if (buttons !== exp_flat() || changed !== exp_chg) begin
          n_fail++;
          $display("FAIL auto_word: got %h/%b want %h/%b", buttons, changed, exp_flat(), exp_chg);
        end
      end
    end
    n_tests++;
    if (rises.size() < 3) begin
      n_fail++;
      $display("FAIL auto_polls: got %0d latch edges want 3", rises.size());
    end else if (rises[1] - rises[0] != PP || rises[2] - rises[1] != PP) begin
      n_fail++;
      $display("FAIL auto_period: got %0d,%0d want %0d", rises[1] - rises[0],
               rises[2] - rises[1], PP);
    end
    auto_en = 1'b0;
    for (int n = 0; n < LAT + 10 && got_valid == 0; n++) begin
      @(posedge PCLK);
      #1;
      if (valid) begin
        got_valid = 1;
        model_poll();
      end
    end
    n_tests++;
    if (got_valid == 0 || buttons !== exp_flat()) begin
      n_fail++;
      $display("FAIL auto_off_finish: got valid=%0d btn=%h want 1 %h", got_valid, buttons,
               exp_flat());
    end
    prev_cw = contWrite;
    for (int n = 0; n < 250; n++) begin
      @(posedge PCLK);
      #1;
      if (contWrite && !prev_cw) extra++;
      prev_cw = contWrite;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL auto_off_quiet: got %0d latch edges want 0", extra);
    end
  endtask

`ifdef CONT_DEBOUNCE_EN
  task automatic test_debounce();
    logic [NB-1:0] seq [3] = '{8'h01, 8'h02, 8'h02};
    logic [NB-1:0] want [3] = '{8'h00, 8'h00, 8'h02};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_poll("debounce", seq[i], 8'h00, -1);
      n_tests++;
      if (buttons[NB-1:0] !== want[i]) begin
        n_fail++;
        $display("FAIL debounce_step%0d: got %h want %h", i, buttons[NB-1:0], want[i]);
      end
    end
  endtask
`endif

  initial begin
    pad_word[0] = '0;
    pad_word[1] = '0;
    model_reset();
    test_reset();
    test_basic();
    test_busy_start();
    test_random();
    test_mid_reset();
    test_auto();
`ifdef CONT_DEBOUNCE_EN
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
